// File: rtl/adc_ad7175_bus_if.sv
// DSP bus register block for the AD7175 controller: command launch with start/busy handshake,
// single-read result latching, status flags and coherent 2x16 reads of the 24-bit cc channels.
module adc_ad7175_bus_if #(
  parameter int START_TIMEOUT = 64
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic [3:0]  bus_addr_i,
  input  logic [15:0] bus_wdata_i,
  input  logic        bus_wr_stb_i,
  input  logic        bus_rd_stb_i,
  output logic [15:0] bus_rdata_o,
  output logic        start_ctrl_o,
  output logic [3:0]  action_o,
  output logic [7:0]  communications_register_o,
  output logic [23:0] data_to_write_o,
  input  logic        ctrl_busy_i,
  input  logic        cc_read_busy_i,
  input  logic [31:0] data_read_i,
  input  logic [23:0] adc_data_0_i,
  input  logic [23:0] adc_data_1_i,
  input  logic [23:0] adc_data_2_i,
  input  logic [23:0] adc_data_3_i
);

  localparam int TW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_DONE, S_PULSE} state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic            start_q;
  logic [3:0]      action_q;
  logic [7:0]      comm_q;
  logic [23:0]     dtw_q;

  logic [15:0]     wlo_q, wlo_d;
  logic [7:0]      whi_q, whi_d;
  logic [31:0]     rd_q, rd_d;
  logic            done_q, done_d, rej_q, rej_d, to_q, to_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [3:0][7:0] hold_q, hold_d;

  logic [3:0][23:0] adc;
  logic [3:0]       cmd_act;
  logic [1:0]       adc_n;
  logic             wr_cmd, cmd_ok, cmd_accept, cmd_reject;
  logic             done_evt, timeout_evt, rd_status, rd_hi, busy;
  logic [15:0]      status;

  assign adc        = {adc_data_3_i, adc_data_2_i, adc_data_1_i, adc_data_0_i};
  assign cmd_act    = bus_wdata_i[3:0];
  assign wr_cmd     = bus_wr_stb_i && (bus_addr_i == 4'd0);
  assign cmd_ok     = (state_q == S_IDLE) && (cmd_act <= 4'd8) &&
                      !((cmd_act <= 4'd7) && cc_read_busy_i);
  assign cmd_accept = wr_cmd && cmd_ok;
  assign cmd_reject = wr_cmd && !cmd_ok;

  assign done_evt    = (state_q == S_WAIT_DONE) && !ctrl_busy_i;
  assign timeout_evt = (state_q == S_ASSERT) && !ctrl_busy_i && (timer_q == TMAX);
  assign rd_status   = bus_rd_stb_i && (bus_addr_i == 4'd0);
  assign rd_hi       = bus_rd_stb_i && (bus_addr_i == 4'd2);
  assign busy        = (state_q != S_IDLE) || ctrl_busy_i;
  assign status      = {4'h0, action_q, 3'b000, to_q, rej_q, done_q, cc_read_busy_i, busy};

  // Addresses 4..11 map pairwise onto channels 0..3; the subtraction wraps mod 4.
  assign adc_n = bus_addr_i[2:1] - 2'd2;

  always_comb begin
    wlo_d   = wlo_q;
    whi_d   = whi_q;
    rd_d    = done_evt ? data_read_i : rd_q;
    done_d  = done_evt    || (done_q && !rd_hi);
    rej_d   = cmd_reject  || (rej_q  && !rd_status);
    to_d    = timeout_evt || (to_q   && !rd_status);
    rdata_d = rdata_q;
    hold_d  = hold_q;
    if (bus_wr_stb_i) begin
      case (bus_addr_i)
        4'd1:    wlo_d = bus_wdata_i;
        4'd2:    whi_d = bus_wdata_i[7:0];
        default: ;
      endcase
    end
    if (bus_rd_stb_i) begin
      case (bus_addr_i)
        4'd0:                    rdata_d = status;
        4'd1:                    rdata_d = rd_q[15:0];
        4'd2:                    rdata_d = rd_q[31:16];
        4'd4, 4'd6, 4'd8, 4'd10: begin
          // Upper byte is frozen now so the following odd-address read is coherent.
          rdata_d        = adc[adc_n][15:0];
          hold_d[adc_n]  = adc[adc_n][23:16];
        end
        4'd5, 4'd7, 4'd9, 4'd11: rdata_d = {8'h00, hold_q[adc_n]};
        default:                 rdata_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      wlo_q   <= '0;
      whi_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
      hold_q  <= '0;
    end else begin
      wlo_q   <= wlo_d;
      whi_q   <= whi_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      start_q  <= 1'b0;
      action_q <= '0;
      comm_q   <= '0;
      dtw_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_accept) begin
            action_q <= cmd_act;
            comm_q   <= bus_wdata_i[15:8];
            dtw_q    <= {whi_q, wlo_q};
            start_q  <= 1'b1;
            timer_q  <= '0;
            state_q  <= (cmd_act <= 4'd6) ? S_ASSERT : S_PULSE;
          end
        end
        S_PULSE: begin
          start_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ASSERT: begin
          if (ctrl_busy_i) begin
            start_q <= 1'b0;
            state_q <= S_WAIT_DONE;
          end else if (timer_q == TMAX) begin
            start_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!ctrl_busy_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_rdata_o               = rdata_q;
  assign start_ctrl_o              = start_q;
  assign action_o                  = action_q;
  assign communications_register_o = comm_q;
  assign data_to_write_o           = dtw_q;

endmodule
